lc3_decode_stage: RTL and testbench

- Pipeline stage directly downstream of instruction fetch and upstream of execute in the LC-3 core.
- Accepts a 16-bit instruction word plus its PC over a valid/ready handshake and classifies it by the 4-bit opcode set in the opcodes package.
- Produces registered decoded fields: register indices, sign-extended immediate and control flags.
- Flags RTI (1000) and reserved (1101) opcodes as illegal.

---
 rtl/lc3_decode_pkg.sv | 42 ++++
 rtl/lc3_decode_comb.sv | 136 +++++++++++++
 rtl/lc3_decode_stage.sv | 148 ++++++++++++++
 tb/tb_lc3_decode_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_decode_pkg.sv
// Shared types and constants for the LC-3 decode stage: opcode values,
// immediate-kind selector and the decoded instruction record.
package lc3_decode_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [3:0] RTI = 4'b1000;
  localparam logic [3:0] RSV = 4'b1101;
  localparam logic [2:0] R7  = 3'd7;

  typedef enum logic [2:0] {IMM5, OFF6, OFF9, OFF11, TRAP8, NONE} imm_kind_e;

  typedef struct packed {
    logic [15:0] pc;
    logic [3:0]  opcode;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic        imm_mode;
    logic [15:0] imm;
    logic [2:0]  nzp;
    logic        writes_reg;
    logic        sets_cc;
    logic        is_mem;
    logic        is_branch;
    logic        illegal;
  } decoded_t;

endpackage

// File: rtl/lc3_decode_comb.sv
// Purely combinational LC-3 instruction decoder: instruction word + PC -> decoded_t.
module lc3_decode_comb
  import lc3_decode_pkg::*;
#(
  parameter bit CHECK_RESERVED = 1'b1
) (
  input  logic [15:0] instr,
  input  logic [15:0] pc,
  output decoded_t    dec
);

  imm_kind_e kind_s;
  logic      rsv_bad_s;
  logic      bad_op_s;
  logic      wr_s;
  logic      cc_s;
  logic      mem_s;
  logic      br_s;

  // Per-opcode field selection, class flags and must-be-fixed bit checks
  always_comb begin
    dec            = '0;
    dec.pc         = pc;
    dec.opcode     = instr[15:12];
    dec.dr         = instr[11:9];
    dec.sr1        = instr[8:6];
    dec.sr2        = instr[2:0];
    dec.imm_mode   = 1'b0;
    dec.nzp        = 3'b000;
    kind_s         = NONE;
    rsv_bad_s      = 1'b0;
    bad_op_s       = 1'b0;
    wr_s           = 1'b0;
    cc_s           = 1'b0;
    mem_s          = 1'b0;
    br_s           = 1'b0;
    case (instr[15:12])
      OP_BR: begin
        kind_s  = OFF9;
        dec.nzp = instr[11:9];
        br_s    = 1'b1;
      end
      OP_ADD, OP_AND: begin
        dec.imm_mode = instr[5];
        wr_s         = 1'b1;
        cc_s         = 1'b1;
        if (instr[5]) begin
          kind_s = IMM5;
        end else begin
          kind_s    = NONE;
          rsv_bad_s = (instr[4:3] != 2'b00);
        end
      end
      OP_LD, OP_LDI: begin
        kind_s = OFF9;
        wr_s   = 1'b1;
        cc_s   = 1'b1;
        mem_s  = 1'b1;
      end
      OP_ST, OP_STI: begin
        kind_s  = OFF9;
        dec.sr2 = instr[11:9];
        mem_s   = 1'b1;
      end
      OP_JSR: begin
        dec.dr = R7;
        wr_s   = 1'b1;
        br_s   = 1'b1;
        if (instr[11]) begin
          kind_s = OFF11;
        end else begin
          kind_s    = NONE;
          rsv_bad_s = (|instr[10:9]) | (|instr[5:0]);
        end
      end
      OP_LDR: begin
        kind_s = OFF6;
        wr_s   = 1'b1;
        cc_s   = 1'b1;
        mem_s  = 1'b1;
      end
      OP_STR: begin
        kind_s  = OFF6;
        dec.sr2 = instr[11:9];
        mem_s   = 1'b1;
      end
      OP_NOT: begin
        wr_s      = 1'b1;
        cc_s      = 1'b1;
        rsv_bad_s = (instr[5:0] != 6'h3F);
      end
      OP_JMP: begin
        br_s      = 1'b1;
        rsv_bad_s = (|instr[11:9]) | (|instr[5:0]);
      end
      OP_LEA: begin
        kind_s = OFF9;
        wr_s   = 1'b1;
      end
      OP_TRAP: begin
        kind_s    = TRAP8;
        dec.dr    = R7;
        wr_s      = 1'b1;
        br_s      = 1'b1;
        rsv_bad_s = |instr[11:8];
      end
      RTI, RSV: bad_op_s = 1'b1;
      default:  bad_op_s = 1'b1;
    endcase

    case (kind_s)
      IMM5:    dec.imm = {{11{instr[4]}}, instr[4:0]};
      OFF6:    dec.imm = {{10{instr[5]}}, instr[5:0]};
      OFF9:    dec.imm = {{7{instr[8]}}, instr[8:0]};
      OFF11:   dec.imm = {{5{instr[10]}}, instr[10:0]};
      TRAP8:   dec.imm = {8'h00, instr[7:0]};
      NONE:    dec.imm = 16'h0000;
      default: dec.imm = 16'h0000;
    endcase

    dec.illegal = bad_op_s | (CHECK_RESERVED & rsv_bad_s);
    // Illegal encodings still travel downstream but must not cause any side effect
    if (dec.illegal) begin
      dec.writes_reg = 1'b0;
      dec.sets_cc    = 1'b0;
      dec.is_mem     = 1'b0;
      dec.is_branch  = 1'b0;
    end else begin
      dec.writes_reg = wr_s;
      dec.sets_cc    = cc_s;
      dec.is_mem     = mem_s;
      dec.is_branch  = br_s;
    end
  end

endmodule

// File: rtl/lc3_decode_stage.sv
// LC-3 decode pipeline stage: registered decode behind a valid/ready handshake.
// Optional macro LC3_DECODE_SKID_EN adds a skid entry and a registered in_ready.
module lc3_decode_stage
  import lc3_decode_pkg::*;
#(
  parameter bit CHECK_RESERVED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  input  logic [15:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_pc,
  output logic [3:0]  out_opcode,
  output logic [2:0]  out_dr,
  output logic [2:0]  out_sr1,
  output logic [2:0]  out_sr2,
  output logic        out_imm_mode,
  output logic [15:0] out_imm,
  output logic [2:0]  out_nzp,
  output logic        out_writes_reg,
  output logic        out_sets_cc,
  output logic        out_is_mem,
  output logic        out_is_branch,
  output logic        out_illegal
);

  decoded_t dec_s;
  decoded_t out_r;
  decoded_t out_nxt_s;
  logic     out_valid_r;
  logic     out_valid_nxt_s;
  logic     accept_s;

  lc3_decode_comb #(.CHECK_RESERVED(CHECK_RESERVED)) u_comb (
    .instr (in_instr),
    .pc    (in_pc),
    .dec   (dec_s)
  );

`ifdef LC3_DECODE_SKID_EN
  decoded_t skid_r;
  decoded_t skid_nxt_s;
  logic     skid_valid_r;
  logic     skid_valid_nxt_s;
  logic     in_ready_r;
  logic     advance_s;

  assign in_ready  = in_ready_r;
  assign accept_s  = in_valid & in_ready_r;
  assign advance_s = ~out_valid_r | out_ready;

  // Next state for output register and skid entry; the skid entry drains first
  always_comb begin
    out_nxt_s        = out_r;
    out_valid_nxt_s  = out_valid_r;
    skid_nxt_s       = skid_r;
    skid_valid_nxt_s = skid_valid_r;
    if (flush) begin
      out_valid_nxt_s  = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else if (skid_valid_r) begin
      if (advance_s) begin
        out_nxt_s        = skid_r;
        out_valid_nxt_s  = 1'b1;
        skid_valid_nxt_s = 1'b0;
      end else begin
        out_valid_nxt_s  = out_valid_r;
      end
    end else if (accept_s) begin
      if (advance_s) begin
        out_nxt_s        = dec_s;
        out_valid_nxt_s  = 1'b1;
      end else begin
        skid_nxt_s       = dec_s;
        skid_valid_nxt_s = 1'b1;
      end
    end else if (advance_s) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end

  // Skid entry and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_r       <= '0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      skid_r       <= skid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      in_ready_r   <= ~skid_valid_nxt_s;
    end
  end
`else
  assign in_ready = ~out_valid_r | out_ready;
  assign accept_s = in_valid & in_ready;

  // Next state for the single output register; flush wins over a same-cycle accept
  always_comb begin
    out_nxt_s       = out_r;
    out_valid_nxt_s = out_valid_r;
    if (flush) begin
      out_valid_nxt_s = 1'b0;
    end else if (accept_s) begin
      out_nxt_s       = dec_s;
      out_valid_nxt_s = 1'b1;
    end else if (out_ready) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end
`endif

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r       <= '0;
      out_valid_r <= 1'b0;
    end else begin
      out_r       <= out_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  assign out_valid      = out_valid_r;
  assign out_pc         = out_r.pc;
  assign out_opcode     = out_r.opcode;
  assign out_dr         = out_r.dr;
  assign out_sr1        = out_r.sr1;
  assign out_sr2        = out_r.sr2;
  assign out_imm_mode   = out_r.imm_mode;
  assign out_imm        = out_r.imm;
  assign out_nzp        = out_r.nzp;
  assign out_writes_reg = out_r.writes_reg;
  assign out_sets_cc    = out_r.sets_cc;
  assign out_is_mem     = out_r.is_mem;
  assign out_is_branch  = out_r.is_branch;
  assign out_illegal    = out_r.illegal;

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Directed self-checking bench for lc3_decode_stage (default build or LC3_DECODE_SKID_EN).
module tb_lc3_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [15:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc;
  logic [3:0]  out_opcode;
  logic [2:0]  out_dr;
  logic [2:0]  out_sr1;
  logic [2:0]  out_sr2;
  logic        out_imm_mode;
  logic [15:0] out_imm;
  logic [2:0]  out_nzp;
  logic        out_writes_reg;
  logic        out_sets_cc;
  logic        out_is_mem;
  logic        out_is_branch;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  // flags = {writes_reg, sets_cc, is_mem, is_branch, illegal}
  typedef struct {
    logic [15:0] instr;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic        im;
    logic [15:0] imm;
    logic [2:0]  nzp;
    logic [4:0]  fl;
  } vec_t;

  vec_t vec [16];

  lc3_decode_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .in_pc          (in_pc),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_opcode     (out_opcode),
    .out_dr         (out_dr),
    .out_sr1        (out_sr1),
    .out_sr2        (out_sr2),
    .out_imm_mode   (out_imm_mode),
    .out_imm        (out_imm),
    .out_nzp        (out_nzp),
    .out_writes_reg (out_writes_reg),
    .out_sets_cc    (out_sets_cc),
    .out_is_mem     (out_is_mem),
    .out_is_branch  (out_is_branch),
    .out_illegal    (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input vec_t v, input logic [15:0] pc, input string tag);
    check_eq({tag, "_valid"}, out_valid, 1'b1);
    check_eq({tag, "_pc"},    out_pc, pc);
    check_eq({tag, "_op"},    out_opcode, v.instr[15:12]);
    check_eq({tag, "_dr"},    out_dr, v.dr);
    check_eq({tag, "_sr1"},   out_sr1, v.sr1);
    check_eq({tag, "_sr2"},   out_sr2, v.sr2);
    check_eq({tag, "_immm"},  out_imm_mode, v.im);
    check_eq({tag, "_imm"},   out_imm, v.imm);
    check_eq({tag, "_nzp"},   out_nzp, v.nzp);
    check_eq({tag, "_flags"},
             {out_writes_reg, out_sets_cc, out_is_mem, out_is_branch, out_illegal}, v.fl);
  endtask

  initial begin
    int send;
    int recv;
    logic held;
    logic [15:0] held_pc;
    logic [15:0] held_imm;

    vec[0]  = '{16'h1262, 3'd1, 3'd1, 3'd2, 1'b1, 16'h0002, 3'd0, 5'b11000};
    vec[1]  = '{16'h103F, 3'd0, 3'd0, 3'd7, 1'b1, 16'hFFFF, 3'd0, 5'b11000};
    vec[2]  = '{16'h25FD, 3'd2, 3'd7, 3'd5, 1'b0, 16'hFFFD, 3'd0, 5'b11100};
    vec[3]  = '{16'h0FFF, 3'd7, 3'd7, 3'd7, 1'b0, 16'hFFFF, 3'd7, 5'b00010};
    vec[4]  = '{16'h7705, 3'd3, 3'd4, 3'd3, 1'b0, 16'h0005, 3'd0, 5'b00100};
    vec[5]  = '{16'hF025, 3'd7, 3'd0, 3'd5, 1'b0, 16'h0025, 3'd0, 5'b10010};
    vec[6]  = '{16'h8000, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 3'd0, 5'b00001};
    vec[7]  = '{16'hD000, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 3'd0, 5'b00001};
    vec[8]  = '{16'h9000, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 3'd0, 5'b00001};
    vec[9]  = '{16'h903F, 3'd0, 3'd0, 3'd7, 1'b0, 16'h0000, 3'd0, 5'b11000};
    vec[10] = '{16'h0000, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 3'd0, 5'b00010};
    vec[11] = '{16'h1058, 3'd0, 3'd1, 3'd0, 1'b0, 16'h0000, 3'd0, 5'b00001};
    vec[12] = '{16'h4801, 3'd7, 3'd0, 3'd1, 1'b0, 16'h0001, 3'd0, 5'b10010};
    vec[13] = '{16'h4080, 3'd7, 3'd2, 3'd0, 1'b0, 16'h0000, 3'd0, 5'b10010};
    vec[14] = '{16'hE5FF, 3'd2, 3'd7, 3'd7, 1'b0, 16'hFFFF, 3'd0, 5'b10000};
    vec[15] = '{16'hC1C0, 3'd0, 3'd7, 3'd0, 1'b0, 16'h0000, 3'd0, 5'b00010};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 16'h0000;
    in_pc     = 16'h0000;
    flush     = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_pc", out_pc, 16'h0000);
    check_eq("rst_imm", out_imm, 16'h0000);
    check_eq("rst_flags",
             {out_opcode, out_dr, out_writes_reg, out_is_branch, out_illegal}, 10'h000);
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", in_ready, 1'b1);

    // one instruction per cycle, execute always ready
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = vec[i].instr;
      in_pc    = 16'h3000 + 16'(2 * i);
      #1;
      check_eq($sformatf("v%0d_in_ready", i), in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check_vec(vec[i], 16'h3000 + 16'(2 * i), $sformatf("v%0d", i));
    end
    @(negedge clk);
    #1;
    check_eq("drain_valid", out_valid, 1'b0);

    // stream of 4 with a 3-cycle stall mid-stream
    send = 0;
    recv = 0;
    held = 1'b0;
    held_pc = 16'h0000;
    held_imm = 16'h0000;
    for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
      @(negedge clk);
      in_valid  = (send < 4);
      in_instr  = vec[send].instr;
      in_pc     = 16'h4000 + 16'(send);
      out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      if (held) begin
        check_eq("bp_hold_valid", out_valid, 1'b1);
        check_eq("bp_hold_pc", out_pc, held_pc);
        check_eq("bp_hold_imm", out_imm, held_imm);
      end
      if (out_valid && out_ready) begin
        check_vec(vec[recv], 16'h4000 + 16'(recv), $sformatf("bp%0d", recv));
        recv++;
        held = 1'b0;
      end else if (out_valid) begin
        held     = 1'b1;
        held_pc  = out_pc;
        held_imm = out_imm;
      end else begin
        held = 1'b0;
      end
      if (in_valid && in_ready) send++;
    end
    check_eq("bp_recv_count", recv, 4);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check_eq("bp_drained", out_valid, 1'b0);

    // flush while stalled
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = vec[4].instr;
    in_pc     = 16'h5000;
    @(negedge clk);
    in_instr  = vec[5].instr;
    in_pc     = 16'h5002;
    @(negedge clk);
    in_valid  = 1'b0;
    #1;
    check_vec(vec[4], 16'h5000, "stall");
    check_eq("stall_in_ready", in_ready, 1'b0);
`ifdef LC3_DECODE_SKID_EN
    out_ready = 1'b1;
    #1;
    check_eq("skid_ready_no_comb", in_ready, 1'b0);
    out_ready = 1'b0;
`endif
    @(negedge clk);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = vec[6].instr;
    in_pc     = 16'h5004;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("flush_valid", out_valid, 1'b0);
    check_eq("flush_in_ready", in_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check_eq($sformatf("flush_empty%0d", k), out_valid, 1'b0);
    end

    // asynchronous reset mid-stream
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = vec[0].instr;
    in_pc    = 16'h6000;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_eq("pre_rst_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", out_valid, 1'b0);
    check_eq("async_rst_pc", out_pc, 16'h0000);
    check_eq("async_rst_dr", out_dr, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_in_ready", in_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
